// File: rtl/mmio_reg_responder.sv
// AXI4-Lite slave exposing scratch, control, interrupt status/clear and a 64-bit
// free-running cycle counter with a high-word shadow for coherent 64-bit reads.
module mmio_reg_responder #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    uncoreclk,
  input  logic                    uncore_rstn,
  input  logic [ADDR_WIDTH-1:0]   s_axilite_awaddr,
  input  logic                    s_axilite_awvalid,
  output logic                    s_axilite_awready,
  input  logic [DATA_WIDTH-1:0]   s_axilite_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axilite_wstrb,
  input  logic                    s_axilite_wvalid,
  output logic                    s_axilite_wready,
  output logic [1:0]              s_axilite_bresp,
  output logic                    s_axilite_bvalid,
  input  logic                    s_axilite_bready,
  input  logic [ADDR_WIDTH-1:0]   s_axilite_araddr,
  input  logic                    s_axilite_arvalid,
  output logic                    s_axilite_arready,
  output logic [DATA_WIDTH-1:0]   s_axilite_rdata,
  output logic [1:0]              s_axilite_rresp,
  output logic                    s_axilite_rvalid,
  input  logic                    s_axilite_rready,
  input  logic                    intr0,
  input  logic                    intr1,
  output logic                    irq,
  output logic [7:0]              led
);

  localparam logic [9:0] OFF_SCRATCH = 10'd0;
  localparam logic [9:0] OFF_CTRL    = 10'd1;
  localparam logic [9:0] OFF_STATUS  = 10'd2;
  localparam logic [9:0] OFF_IRQ_CLR = 10'd3;
  localparam logic [9:0] OFF_CYC_LO  = 10'd4;
  localparam logic [9:0] OFF_CYC_HI  = 10'd5;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  logic                    ready_en;
  logic                    aw_full;
  logic [9:0]              aw_off;
  logic                    w_full;
  logic [DATA_WIDTH-1:0]   w_data;
  logic [DATA_WIDTH/8-1:0] w_strb;
  logic [DATA_WIDTH-1:0]   scratch;
  logic [9:0]              ctrl;
  logic [1:0]              pending;
  logic [1:0]              intr_prev;
  logic [63:0]             cyc_cnt;
  logic [31:0]             cyc_shadow;

  logic                    aw_hs, w_hs, ar_hs, commit;
  logic [9:0]              ar_off;
  logic [1:0]              wr_resp, rd_resp;
  logic                    scratch_we, ctrl_we;
  logic [1:0]              clr_mask, rise;
  logic [DATA_WIDTH-1:0]   rd_data, scratch_merged, ctrl_merged;

  function automatic logic [DATA_WIDTH-1:0] merge_bytes(
    input logic [DATA_WIDTH-1:0]   old_val,
    input logic [DATA_WIDTH-1:0]   new_val,
    input logic [DATA_WIDTH/8-1:0] strb
  );
    logic [DATA_WIDTH-1:0] res;
    res = old_val;
    for (int i = 0; i < DATA_WIDTH/8; i++) begin
      if (strb[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

  // ready_en keeps every ready low while in reset and for the first edge after it.
  assign s_axilite_awready = ready_en & ~aw_full & ~s_axilite_bvalid;
  assign s_axilite_wready  = ready_en & ~w_full  & ~s_axilite_bvalid;
  assign s_axilite_arready = ready_en & ~s_axilite_rvalid;

  assign aw_hs  = s_axilite_awvalid & s_axilite_awready;
  assign w_hs   = s_axilite_wvalid  & s_axilite_wready;
  assign ar_hs  = s_axilite_arvalid & s_axilite_arready;
  assign commit = aw_full & w_full;
  assign ar_off = s_axilite_araddr[11:2];
  assign rise   = {intr1, intr0} & ~intr_prev;
  assign led    = ctrl[7:0];

  assign scratch_merged = merge_bytes(scratch, w_data, w_strb);
  assign ctrl_merged    = merge_bytes({{(DATA_WIDTH-10){1'b0}}, ctrl}, w_data, w_strb);

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    wr_resp    = RESP_DECERR;
    scratch_we = 1'b0;
    ctrl_we    = 1'b0;
    clr_mask   = 2'b00;
    case (aw_off)
      OFF_SCRATCH: begin wr_resp = RESP_OKAY; scratch_we = commit; end
      OFF_CTRL:    begin wr_resp = RESP_OKAY; ctrl_we = commit; end
      OFF_IRQ_CLR: begin
        wr_resp  = RESP_OKAY;
        clr_mask = (commit && w_strb[0]) ? w_data[1:0] : 2'b00;
      end
      OFF_STATUS, OFF_CYC_LO, OFF_CYC_HI: wr_resp = RESP_SLVERR;
      default: wr_resp = RESP_DECERR;
    endcase
  end

  always_comb begin
    rd_data = '0;
    rd_resp = RESP_OKAY;
    case (ar_off)
      OFF_SCRATCH: rd_data = scratch;
      OFF_CTRL:    rd_data = {{(DATA_WIDTH-10){1'b0}}, ctrl};
      OFF_STATUS:  rd_data = {{(DATA_WIDTH-2){1'b0}}, pending};
      OFF_IRQ_CLR: rd_data = '0;
      OFF_CYC_LO:  rd_data = cyc_cnt[31:0];
      OFF_CYC_HI:  rd_data = cyc_shadow;
      default:     rd_resp = RESP_DECERR;
    endcase
  end

  // AXI channel state: holdings, write response and read data.
  always_ff @(posedge uncoreclk or negedge uncore_rstn) begin
    if (!uncore_rstn) begin
      ready_en         <= 1'b0;
      aw_full          <= 1'b0;
      aw_off           <= '0;
      w_full           <= 1'b0;
      w_data           <= '0;
      w_strb           <= '0;
      s_axilite_bvalid <= 1'b0;
      s_axilite_bresp  <= '0;
      s_axilite_rvalid <= 1'b0;
      s_axilite_rdata  <= '0;
      s_axilite_rresp  <= '0;
    end else begin
      // NOTE: non-blocking assignments so all registers sample pre-edge values together.
      ready_en <= 1'b1;
      if (aw_hs) begin
        aw_full <= 1'b1;
        aw_off  <= s_axilite_awaddr[11:2];
      end else if (commit) begin
        aw_full <= 1'b0;
      end
      if (w_hs) begin
        w_full <= 1'b1;
        w_data <= s_axilite_wdata;
        w_strb <= s_axilite_wstrb;
      end else if (commit) begin
        w_full <= 1'b0;
      end
      if (commit) begin
        s_axilite_bvalid <= 1'b1;
        s_axilite_bresp  <= wr_resp;
      end else if (s_axilite_bready) begin
        s_axilite_bvalid <= 1'b0;
      end
      if (ar_hs) begin
        s_axilite_rvalid <= 1'b1;
        s_axilite_rdata  <= rd_data;
        s_axilite_rresp  <= rd_resp;
      end else if (s_axilite_rready) begin
        s_axilite_rvalid <= 1'b0;
      end
    end
  end

  // Register file, interrupt tracking and cycle counter.
  always_ff @(posedge uncoreclk or negedge uncore_rstn) begin
    if (!uncore_rstn) begin
      scratch    <= '0;
      ctrl       <= '0;
      pending    <= '0;
      intr_prev  <= '0;
      irq        <= 1'b0;
      cyc_cnt    <= '0;
      cyc_shadow <= '0;
    end else begin
      if (scratch_we) scratch <= scratch_merged;
      if (ctrl_we)    ctrl    <= ctrl_merged[9:0];
      // A new rising edge overrides a clear of the same bit.
      pending   <= (pending & ~clr_mask) | rise;
      intr_prev <= {intr1, intr0};
      irq       <= |(pending & ctrl[9:8]);
      cyc_cnt   <= cyc_cnt + 64'd1;
      if (ar_hs && ar_off == OFF_CYC_LO) cyc_shadow <= cyc_cnt[63:32];
    end
  end

  logic unused_bits;
  assign unused_bits = ^{s_axilite_awaddr[ADDR_WIDTH-1:12], s_axilite_awaddr[1:0],
                         s_axilite_araddr[ADDR_WIDTH-1:12], s_axilite_araddr[1:0],
                         ctrl_merged[DATA_WIDTH-1:10]};

endmodule

// File: tb/tb_mmio_reg_responder.sv
// Scoreboard bench for mmio_reg_responder: expected B/R responses are queued as
// each transaction is issued and compared when the slave presents them.
module tb_mmio_reg_responder;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        chk;
  } rexp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] awaddr = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;
  logic [31:0] araddr = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b0;
  logic        intr0 = 1'b0;
  logic        intr1 = 1'b0;
  logic        irq;
  logic [7:0]  led;

  int          vectors = 0;
  int          miscompares = 0;
  logic [1:0]  bq[$];
  rexp_t       rq[$];
  logic [1:0]  b_exp;
  rexp_t       r_exp;
  logic [31:0] last_rdata = '0;
  logic [31:0] lo_val;

  always #5 clk = ~clk;

  mmio_reg_responder #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .uncoreclk(clk), .uncore_rstn(rst_n),
    .s_axilite_awaddr(awaddr), .s_axilite_awvalid(awvalid), .s_axilite_awready(awready),
    .s_axilite_wdata(wdata), .s_axilite_wstrb(wstrb), .s_axilite_wvalid(wvalid),
    .s_axilite_wready(wready),
    .s_axilite_bresp(bresp), .s_axilite_bvalid(bvalid), .s_axilite_bready(bready),
    .s_axilite_araddr(araddr), .s_axilite_arvalid(arvalid), .s_axilite_arready(arready),
    .s_axilite_rdata(rdata), .s_axilite_rresp(rresp), .s_axilite_rvalid(rvalid),
    .s_axilite_rready(rready),
    .intr0(intr0), .intr1(intr1), .irq(irq), .led(led)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Response monitor: a handshake is about to happen at the next rising edge.
  always @(negedge clk) begin
    if (rst_n && bvalid && bready) begin
      if (bq.size() == 0) check("b_unexpected", 1, 0);
      else begin
        b_exp = bq.pop_front();
        check("bresp", bresp, b_exp);
      end
    end
    if (rst_n && rvalid && rready) begin
      last_rdata = rdata;
      if (rq.size() == 0) check("r_unexpected", 1, 0);
      else begin
        r_exp = rq.pop_front();
        check("rresp", rresp, r_exp.resp);
        if (r_exp.chk) check("rdata", rdata, r_exp.data);
      end
    end
  end

  // All driver tasks start and end just after a rising edge.
  task automatic send_aw(input logic [31:0] a);
    int n = 0;
    awaddr = a; awvalid = 1'b1;
    @(negedge clk);
    while (!awready && n < 50) begin n++; @(negedge clk); end
    if (!awready) check("aw_timeout", 0, 1);
    @(posedge clk); #1 awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s);
    int n = 0;
    wdata = d; wstrb = s; wvalid = 1'b1;
    @(negedge clk);
    while (!wready && n < 50) begin n++; @(negedge clk); end
    if (!wready) check("w_timeout", 0, 1);
    @(posedge clk); #1 wvalid = 1'b0;
  endtask

  task automatic send_ar(input logic [31:0] a);
    int n = 0;
    araddr = a; arvalid = 1'b1;
    @(negedge clk);
    while (!arready && n < 50) begin n++; @(negedge clk); end
    if (!arready) check("ar_timeout", 0, 1);
    @(posedge clk); #1 arvalid = 1'b0;
  endtask

  task automatic collect_b();
    int n = 0;
    bready = 1'b1;
    @(negedge clk);
    while (!bvalid && n < 50) begin n++; @(negedge clk); end
    if (!bvalid) check("b_timeout", 0, 1);
    @(posedge clk); #1 bready = 1'b0;
  endtask

  task automatic collect_r();
    int n = 0;
    rready = 1'b1;
    @(negedge clk);
    while (!rvalid && n < 50) begin n++; @(negedge clk); end
    if (!rvalid) check("r_timeout", 0, 1);
    @(posedge clk); #1 rready = 1'b0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                    input logic [1:0] exp);
    bq.push_back(exp);
    send_aw(a);
    send_w(d, s);
    collect_b();
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] exp_d, input logic [1:0] exp_r);
    rq.push_back('{exp_d, exp_r, 1'b1});
    send_ar(a);
    collect_r();
  endtask

  task automatic rd_any(input logic [31:0] a);
    rq.push_back('{32'h0, OKAY, 1'b0});
    send_ar(a);
    collect_r();
  endtask

  task automatic cycles(input int k);
    repeat (k) begin @(posedge clk); #1; end
  endtask

  task automatic reset_and_check();
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_awready", awready, 0); check("rst_wready", wready, 0);
    check("rst_arready", arready, 0); check("rst_bvalid", bvalid, 0);
    check("rst_rvalid", rvalid, 0);   check("rst_irq", irq, 0);
    check("rst_led", led, 0);         check("rst_bresp", bresp, 0);
    check("rst_rresp", rresp, 0);     check("rst_rdata", rdata, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("ready_low_before_first_edge", awready, 0);
    @(negedge clk);
    check("awready_after_rst", awready, 1);
    check("wready_after_rst", wready, 1);
    check("arready_after_rst", arready, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    cycles(3);
    reset_and_check();

    // AW three cycles ahead of W, then readback
    bq.push_back(OKAY);
    send_aw(32'h0);
    cycles(3);
    send_w(32'hA5A5_1234, 4'hF);
    collect_b();
    rd(32'h0, 32'hA5A5_1234, OKAY);

    // W ahead of AW with partial strobes on lanes 0 and 2
    bq.push_back(OKAY);
    send_w(32'hFFFF_FFFF, 4'h5);
    cycles(2);
    send_aw(32'h0);
    collect_b();
    rd(32'h0, 32'hA5FF_12FF, OKAY);

    // CTRL lane gating, decode errors, read-only writes, address aliasing
    wr(32'h04, 32'h0000_03FF, 4'h1, OKAY);
    @(negedge clk); check("led_ff", led, 8'hFF); @(posedge clk); #1;
    rd(32'h04, 32'h0000_00FF, OKAY);
    rd(32'h20, 32'h0, DECERR);
    wr(32'h08, 32'hFFFF_FFFF, 4'hF, SLVERR);
    rd(32'h08, 32'h0, OKAY);
    wr(32'h14, 32'h1234_5678, 4'hF, SLVERR);
    wr(32'h40, 32'h1234_5678, 4'hF, DECERR);
    rd(32'h1007, 32'h0000_00FF, OKAY);
    wr(32'h04, 32'hFFFF_FFFF, 4'hF, OKAY);
    rd(32'h04, 32'h0000_03FF, OKAY);
    wr(32'h04, 32'h0000_0100, 4'h2, OKAY);
    rd(32'h04, 32'h0000_01FF, OKAY);
    rd(32'h0C, 32'h0, OKAY);

    // intr0 pulse with CTRL[9:8]=01
    intr0 = 1'b1; cycles(1); intr0 = 1'b0;
    cycles(2);
    @(negedge clk); check("irq_after_intr0", irq, 1); @(posedge clk); #1;
    rd(32'h08, 32'h1, OKAY);

    // IRQ_CLR commit coincides with a fresh intr0 rise: set wins
    bq.push_back(OKAY);
    send_aw(32'h0C);
    send_w(32'h1, 4'h1);
    intr0 = 1'b1;
    collect_b();
    intr0 = 1'b0;
    rd(32'h08, 32'h1, OKAY);
    @(negedge clk); check("irq_kept", irq, 1); @(posedge clk); #1;

    // STATUS read in the IRQ_CLR commit cycle sees the pre-clear value
    bq.push_back(OKAY);
    rq.push_back('{32'h1, OKAY, 1'b1});
    send_aw(32'h0C);
    send_w(32'h1, 4'h1);
    araddr = 32'h08; arvalid = 1'b1;
    @(negedge clk); check("arready_concurrent", arready, 1);
    @(posedge clk); #1 arvalid = 1'b0;
    collect_b();
    collect_r();
    rd(32'h08, 32'h0, OKAY);
    @(negedge clk); check("irq_cleared", irq, 0); @(posedge clk); #1;

    // intr1 masked off by CTRL[9]=0; clear ignored without wstrb[0]
    intr1 = 1'b1; cycles(1); intr1 = 1'b0;
    cycles(2);
    rd(32'h08, 32'h2, OKAY);
    @(negedge clk); check("irq_masked", irq, 0); @(posedge clk); #1;
    wr(32'h0C, 32'h3, 4'h2, OKAY);
    rd(32'h08, 32'h2, OKAY);
    wr(32'h0C, 32'h2, 4'h1, OKAY);
    rd(32'h08, 32'h0, OKAY);

    // B back-pressure: response held, no new AW/W until the handshake
    bq.push_back(OKAY);
    send_aw(32'h0);
    send_w(32'h1111_2222, 4'hF);
    begin
      int n = 0;
      @(negedge clk);
      while (!bvalid && n < 50) begin n++; @(negedge clk); end
      if (!bvalid) check("b_hold_timeout", 0, 1);
    end
    bq.push_back(OKAY);
    @(posedge clk); #1 awaddr = 32'h0; awvalid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_bvalid", bvalid, 1);
      check("hold_bresp", bresp, OKAY);
      check("hold_awready", awready, 0);
      check("hold_wready", wready, 0);
    end
    @(posedge clk); #1 bready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1 bready = 1'b0;
    @(negedge clk); check("aw_after_b", awready, 1);
    @(posedge clk); #1 awvalid = 1'b0;
    send_w(32'h3333_4444, 4'hF);
    collect_b();
    rd(32'h0, 32'h3333_4444, OKAY);

    // Cycle counter: HI returns the shadow captured by the LO read
    @(posedge clk); #1 force dut.cyc_cnt = 64'h0000_0007_FFFF_FFF8;
    @(posedge clk); #1 release dut.cyc_cnt;
    rd_any(32'h10);
    lo_val = last_rdata;
    check("cyc_lo_near_wrap", (lo_val >= 32'hFFFF_FFF8) ? 1 : 0, 1);
    cycles(5);
    rd(32'h14, 32'h0000_0007, OKAY);
    rd_any(32'h10);
    check("cyc_lo_wrapped", (last_rdata < 32'h0000_1000) ? 1 : 0, 1);
    rd(32'h14, 32'h0000_0008, OKAY);

    // Reset with a lone W in its holding: it must be discarded
    send_w(32'h1234_5678, 4'hF);
    reset_and_check();
    awaddr = 32'h0; awvalid = 1'b1;
    @(posedge clk); #1 awvalid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); check("no_b_after_rst", bvalid, 0);
    end
    @(posedge clk); #1;
    bq.push_back(OKAY);
    send_w(32'hDEAD_BEEF, 4'hF);
    collect_b();
    rd(32'h0, 32'hDEAD_BEEF, OKAY);
    rd(32'h04, 32'h0, OKAY);

    cycles(4);
    check("bq_drained", bq.size(), 0);
    check("rq_drained", rq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

endmodule

// File: doc/mmio_reg_responder.md
MMIO_REG_RESPONDER -- requirements
Module: mmio_reg_responder

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, width of AXI4-Lite address buses.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, fixed data width; no other value supported.
REQ-003 SHALL have one clock and one reset: the reset is asynchronous and active-low.
REQ-004 uncoreclk  input  1  sole clock; all state on its rising edge.
REQ-005 uncore_rstn  input  1  asynchronous active-low reset.
REQ-006 s_axilite_awaddr/awvalid/awready  in/in/out  ADDR_WIDTH/1/1  write address channel.
REQ-007 s_axilite_wdata/wstrb/wvalid/wready  in/in/in/out  32/4/1/1  write data channel.
REQ-008 s_axilite_bresp/bvalid/bready  out/out/in  2/1/1  write response channel.
REQ-009 s_axilite_araddr/arvalid/arready  in/in/out  ADDR_WIDTH/1/1  read address channel.
REQ-010 s_axilite_rdata/rresp/rvalid/rready  out/out/out/in  32/2/1/1  read data channel.
REQ-011 intr0, intr1  input  1 each  level interrupt sources, synchronous to uncoreclk.
REQ-012 irq  output  1  combined masked interrupt.
REQ-013 led  output  8  CTRL[7:0].

Function
REQ-014 SHALL decode offset addr[11:2]; addr[1:0] and addr above bit 11 ignored.
REQ-015 Map: 0x00 SCRATCH rw; 0x04 CTRL rw (bits 9:0 implemented, rest read 0); 0x08 STATUS ro (bits 1:0 = pending); 0x0C IRQ_CLR write-1-to-clear pending, reads 0; 0x10 CYC_LO ro; 0x14 CYC_HI ro; others unmapped.
REQ-016 Write address and write data SHALL each be captured into an independent one-entry holding register; order of AW vs W arrival arbitrary.
REQ-017 awready SHALL be high iff AW holding empty and bvalid low; wready likewise for W holding.
REQ-018 When both holdings full, write SHALL commit that cycle, holdings SHALL clear, bvalid SHALL assert next cycle.
REQ-019 bvalid SHALL hold with bresp stable until bready sampled high; no new AW/W accepted while bvalid high.
REQ-020 wstrb SHALL gate each byte lane on SCRATCH and CTRL; IRQ_CLR uses wdata[1:0] only if wstrb[0].
REQ-021 bresp SHALL be OKAY (00) for rw/IRQ_CLR, SLVERR (10) for STATUS/CYC_LO/CYC_HI (no state change), DECERR (11) for unmapped.
REQ-022 arready SHALL be high iff rvalid low; AR handshake -> rvalid next cycle with registered rdata/rresp.
REQ-023 rvalid, rdata, rresp SHALL hold until rready; unmapped read returns rdata 0, rresp DECERR; all others OKAY.
REQ-024 64-bit cycle counter SHALL increment every cycle and wrap from all-ones to 0.
REQ-025 Reading CYC_LO SHALL latch counter[63:32] into a shadow; CYC_HI read returns the shadow, not the live value.
REQ-026 Pending bit n SHALL set on rising edge of intrn (registered previous value, compare 0->1).
REQ-027 Set and IRQ_CLR on the same bit in the same cycle: set SHALL win.
REQ-028 irq SHALL be registered: irq = |(pending & CTRL[9:8]), one cycle after pending/CTRL update.
REQ-029 Read and write channels SHALL operate concurrently; a read of STATUS in the commit cycle of IRQ_CLR returns the pre-clear value.

Reset
REQ-030 On uncore_rstn low: awready, wready, arready, bvalid, rvalid, irq = 0; bresp, rresp, rdata = 0; SCRATCH, CTRL, pending, counter, shadow, holdings, intr history = 0; led = 0.
REQ-031 awready, wready, arready SHALL rise the first cycle after reset release.
REQ-032 Reset mid-transaction SHALL abandon in-flight transfers with no partial register update.

Verification
REQ-033 AW to 0x00 three cycles before W=0xA5A5_1234 strb 0xF, bready=1 -> one B OKAY; read 0x00 returns 0xA5A5_1234.
REQ-034 Write 0x04 data 0x0000_03FF strb 0x1 -> led=0xFF, CTRL=0x0FF; read 0x20 -> rdata 0, rresp DECERR; write 0x08 -> bresp SLVERR, STATUS unchanged.
REQ-035 CTRL[9:8]=01, pulse intr0 -> STATUS=0x1, irq=1; write IRQ_CLR 0x1 while intr0 re-rises same cycle -> STATUS stays 0x1.
REQ-036 bready held 0 for 10 cycles after W/AW -> bvalid stable, awready/wready 0 throughout; second AW accepted only after B handshake.
REQ-037 Counter forced near 0xFFFF_FFFF in low word: read CYC_LO then CYC_HI 5 cycles later -> HI equals value at LO read, not incremented.
